// File: rtl/rtds_pkg.sv
// Shared types and constants for the ready-to-drive sequencer.
// The state encoding is also the telemetry value reported on rtds_state.
package rtds_pkg;

    localparam int BSE_W = 12;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_RELEASE = 3'd1,
        ARMED        = 3'd2,
        BUZZ         = 3'd3,
        DRIVE        = 3'd4
    } rtds_state_t;

endpackage

// File: rtl/rtds_debounce.sv
// Start-button conditioning: 2-FF synchronizer, stability-count debouncer,
// and a one-cycle pulse on each debounced 0->1 transition.
module rtds_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          rise_q, rise_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
        end
    end

    // The count only runs while the synchronized input disagrees with the
    // debounced level; any agreement restarts the stability window.
    always_comb begin
        db_d   = db_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d   = sync2_q;
                rise_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign dout = db_q;
    assign rise = rise_q;

endmodule

// File: rtl/rtds_sequencer.sv
// Ready-to-drive sequencer: gates drive enable behind SDC, brake and a
// debounced start press, sounding the buzzer for a fixed time first.
module rtds_sequencer
    import rtds_pkg::*;
#(
    parameter logic [BSE_W-1:0] BRAKE_THRESHOLD = 12'd2,
    parameter int               DEBOUNCE_CYCLES = 500_000,
    parameter int               BUZZER_CYCLES   = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SDC_final,
    input  logic [BSE_W-1:0] BSE,
    input  logic             start_button,
    output logic             brake_light,
    output logic             speaker,
    output logic             ready_to_drive,
    output logic [2:0]       rtds_state
);

    localparam int BW = $clog2(BUZZER_CYCLES + 1);
    localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZER_CYCLES - 1);

    logic          sdc_meta_q, sdc_s_q;
    logic          btn_db, btn_rise;
    logic          brake_on;
    rtds_state_t   state_q, state_d;
    logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
    logic          brake_light_q, speaker_q, rtd_q;

    rtds_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk (clk),
        .rst (rst),
        .din (start_button),
        .dout(btn_db),
        .rise(btn_rise)
    );

    assign brake_on = (BSE > BRAKE_THRESHOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdc_meta_q    <= 1'b0;
            sdc_s_q       <= 1'b0;
            state_q       <= IDLE;
            buzz_cnt_q    <= '0;
            brake_light_q <= 1'b1;
            speaker_q     <= 1'b1;
            rtd_q         <= 1'b0;
        end else begin
            sdc_meta_q    <= SDC_final;
            sdc_s_q       <= sdc_meta_q;
            state_q       <= state_d;
            buzz_cnt_q    <= buzz_cnt_d;
            brake_light_q <= ~brake_on;
            speaker_q     <= (state_d != BUZZ);
            rtd_q         <= (state_d == DRIVE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (sdc_s_q) state_d = WAIT_RELEASE;
            WAIT_RELEASE: if (!btn_db) state_d = ARMED;
            ARMED:        if (btn_rise && brake_on) state_d = BUZZ;
            BUZZ:         if (buzz_cnt_q == BUZZ_LAST) state_d = DRIVE;
            DRIVE:        state_d = DRIVE;
            default:      state_d = IDLE;
        endcase
        // An open shutdown circuit overrides everything else.
        if (!sdc_s_q) state_d = IDLE;
    end

    always_comb begin
        buzz_cnt_d = '0;
        if (state_q == BUZZ && state_d == BUZZ) buzz_cnt_d = buzz_cnt_q + 1'b1;
    end

    assign brake_light    = brake_light_q;
    assign speaker        = speaker_q;
    assign ready_to_drive = rtd_q;
    assign rtds_state     = state_q;

endmodule

// File: tb/tb_rtds_sequencer.sv
// Directed bench for rtds_sequencer with short debounce and buzzer periods.
module tb_rtds_sequencer;

    localparam int DEB  = 4;
    localparam int BUZZ_N = 10;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_WR    = 32'd1;
    localparam logic [31:0] S_ARMED = 32'd2;
    localparam logic [31:0] S_BUZZ  = 32'd3;
    localparam logic [31:0] S_DRIVE = 32'd4;

    logic        clk;
    logic        rst;
    logic        sdc;
    logic [11:0] bse;
    logic        btn;
    logic        brake_light;
    logic        speaker;
    logic        ready_to_drive;
    logic [2:0]  rtds_state;

    int n_checks;
    int n_errors;

    rtds_sequencer #(
        .BRAKE_THRESHOLD(12'd2),
        .DEBOUNCE_CYCLES(DEB),
        .BUZZER_CYCLES  (BUZZ_N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .SDC_final     (sdc),
        .BSE           (bse),
        .start_button  (btn),
        .brake_light   (brake_light),
        .speaker       (speaker),
        .ready_to_drive(ready_to_drive),
        .rtds_state    (rtds_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sdc = 1'b0;
        bse = 12'd0;
        btn = 1'b0;
        step(2);
        chk("rst_state", 32'(rtds_state), S_IDLE);
        chk("rst_speaker", 32'(speaker), 32'd1);
        chk("rst_rtd", 32'(ready_to_drive), 32'd0);
        chk("rst_brake_light", 32'(brake_light), 32'd1);
        rst = 1'b0;
        step(1);
    endtask

    // Close SDC from IDLE and wait until the FSM reaches ARMED.
    task automatic arm(input logic [11:0] pressure);
        bse = pressure;
        sdc = 1'b1;
        step(4);
        chk("arm_state", 32'(rtds_state), S_ARMED);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // 1: nominal start, then button in DRIVE, then SDC drop in DRIVE.
        do_reset();
        arm(12'd100);
        chk("s1_brake_light", 32'(brake_light), 32'd0);
        btn = 1'b1;
        step(6);
        chk("s1_pre_buzz_state", 32'(rtds_state), S_ARMED);
        chk("s1_pre_buzz_speaker", 32'(speaker), 32'd1);
        step(1);
        chk("s1_buzz_state", 32'(rtds_state), S_BUZZ);
        chk("s1_buzz_speaker", 32'(speaker), 32'd0);
        btn = 1'b0;
        step(9);
        chk("s1_buzz_last_speaker", 32'(speaker), 32'd0);
        chk("s1_buzz_last_rtd", 32'(ready_to_drive), 32'd0);
        step(1);
        chk("s1_drive_speaker", 32'(speaker), 32'd1);
        chk("s1_drive_rtd", 32'(ready_to_drive), 32'd1);
        chk("s1_drive_state", 32'(rtds_state), S_DRIVE);
        btn = 1'b1;
        step(8);
        chk("s1_btn_in_drive", 32'(rtds_state), S_DRIVE);
        btn = 1'b0;
        step(8);
        sdc = 1'b0;
        step(2);
        chk("s5_drive_drop_early", 32'(ready_to_drive), 32'd1);
        step(1);
        chk("s5_drive_drop_rtd", 32'(ready_to_drive), 32'd0);
        chk("s5_drive_drop_state", 32'(rtds_state), S_IDLE);

        // 2: brake at threshold is not pressed; one above is.
        do_reset();
        arm(12'd2);
        chk("s2_bl_at_thresh", 32'(brake_light), 32'd1);
        btn = 1'b1;
        step(8);
        chk("s2_nobrake_state", 32'(rtds_state), S_ARMED);
        chk("s2_nobrake_speaker", 32'(speaker), 32'd1);
        btn = 1'b0;
        step(8);
        bse = 12'd3;
        chk("s2_bl_latency", 32'(brake_light), 32'd1);
        step(1);
        chk("s2_bl_above", 32'(brake_light), 32'd0);
        btn = 1'b1;
        step(7);
        chk("s2_brake_buzz", 32'(rtds_state), S_BUZZ);
        btn = 1'b0;

        // 3: button held through SDC closure.
        do_reset();
        bse = 12'd100;
        btn = 1'b1;
        step(8);
        sdc = 1'b1;
        step(6);
        chk("s3_held_state", 32'(rtds_state), S_WR);
        chk("s3_held_speaker", 32'(speaker), 32'd1);
        btn = 1'b0;
        step(6);
        chk("s3_release_wait", 32'(rtds_state), S_WR);
        step(1);
        chk("s3_release_armed", 32'(rtds_state), S_ARMED);
        btn = 1'b1;
        step(7);
        chk("s3_repress_buzz", 32'(rtds_state), S_BUZZ);
        btn = 1'b0;

        // 4: glitch rejection, then 5: SDC drop at buzzer count 5.
        do_reset();
        arm(12'd100);
        for (int i = 0; i < 2; i++) begin
            btn = 1'b1;
            step(3);
            btn = 1'b0;
            step(6);
            chk("s4_glitch_state", 32'(rtds_state), S_ARMED);
        end
        btn = 1'b1;
        step(4);
        btn = 1'b0;
        step(3);
        chk("s4_stable_buzz", 32'(rtds_state), S_BUZZ);
        chk("s4_stable_speaker", 32'(speaker), 32'd0);
        step(5);
        sdc = 1'b0;
        step(2);
        chk("s5_buzz_drop_early", 32'(speaker), 32'd0);
        step(1);
        chk("s5_buzz_drop_speaker", 32'(speaker), 32'd1);
        chk("s5_buzz_drop_state", 32'(rtds_state), S_IDLE);
        step(15);
        chk("s5_buzz_drop_no_rtd", 32'(ready_to_drive), 32'd0);

        // 6: asynchronous reset in DRIVE, then a fresh sequence is required.
        do_reset();
        arm(12'd100);
        btn = 1'b1;
        step(7);
        chk("s6_buzz", 32'(rtds_state), S_BUZZ);
        btn = 1'b0;
        step(10);
        chk("s6_drive_rtd", 32'(ready_to_drive), 32'd1);
        rst = 1'b1;
        #1;
        chk("s6_async_rtd", 32'(ready_to_drive), 32'd0);
        chk("s6_async_speaker", 32'(speaker), 32'd1);
        chk("s6_async_brake_light", 32'(brake_light), 32'd1);
        chk("s6_async_state", 32'(rtds_state), S_IDLE);
        step(2);
        sdc = 1'b0;
        btn = 1'b1;
        rst = 1'b0;
        step(8);
        chk("s6_post_rst_idle", 32'(rtds_state), S_IDLE);
        sdc = 1'b1;
        step(6);
        chk("s6_held_wait", 32'(rtds_state), S_WR);
        chk("s6_held_rtd", 32'(ready_to_drive), 32'd0);
        btn = 1'b0;
        step(7);
        chk("s6_release_armed", 32'(rtds_state), S_ARMED);
        btn = 1'b1;
        step(7);
        chk("s6_repress_buzz", 32'(rtds_state), S_BUZZ);
        btn = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
